// File: rtl/fibonacci_engine.sv
// ---------------------------------------------------------------------------
// fibonacci_engine
//
// Iterative Fibonacci calculator. An index n is accepted on a start/ready
// handshake and F(n) is produced at one term per clock. If a term does not
// fit in DATA_W bits, the result is all-ones and overflow is set. done
// pulses for one cycle when fib/overflow become valid.
//
// Parameters:
//   DATA_W  result width in bits (minimum 2)
//   IDX_W   index width in bits; n ranges 0 .. 2**IDX_W-1
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       request, sampled only while ready=1
//   n           index, captured on the accepted start cycle
//   ready       idle and able to accept start
//   done        one-cycle pulse when fib/overflow become valid
//   fib         F(n), or all-ones on overflow; held until the next accept
//   overflow    F(n) not representable in DATA_W bits; held like fib
//   term_valid  stream: t0 is a valid, non-overflowed term (FIB_STREAM_EN)
//   term        stream: current term F(term_idx)           (FIB_STREAM_EN)
//   term_idx    stream: index of the current term          (FIB_STREAM_EN)
//
// Optional feature: define FIB_STREAM_EN to add the stream ports, which
// emit F(0)..F(n) once each, in order, before done.
// ---------------------------------------------------------------------------
module fibonacci_engine #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  n,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] fib,
  output logic              overflow
`ifdef FIB_STREAM_EN
  ,
  output logic              term_valid,
  output logic [DATA_W-1:0] term,
  output logic [IDX_W-1:0]  term_idx
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    cnt_reg, cnt_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [DATA_W-1:0]   t0_reg, t0_next;
  logic [DATA_W-1:0]   t1_reg, t1_next;
  logic                ov0_reg, ov0_next;
  logic                ov1_reg, ov1_next;
  logic [DATA_W-1:0]   fib_reg, fib_next;
  logic                overflow_reg, overflow_next;

  // One extra bit so the carry out of the new term is visible.
  logic [DATA_W:0]     sum;

  assign sum = {1'b0, t0_reg} + {1'b0, t1_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      t0_reg       <= '0;
      t1_reg       <= '0;
      ov0_reg      <= 1'b0;
      ov1_reg      <= 1'b0;
      fib_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      t0_reg       <= t0_next;
      t1_reg       <= t1_next;
      ov0_reg      <= ov0_next;
      ov1_reg      <= ov1_next;
      fib_reg      <= fib_next;
      overflow_reg <= overflow_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    idx_next      = idx_reg;
    t0_next       = t0_reg;
    t1_next       = t1_reg;
    ov0_next      = ov0_reg;
    ov1_next      = ov1_reg;
    fib_next      = fib_reg;
    overflow_next = overflow_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          cnt_next      = n;
          idx_next      = '0;
          t0_next       = '0;
          t1_next       = {{(DATA_W-1){1'b0}}, 1'b1};
          ov0_next      = 1'b0;
          ov1_next      = 1'b0;
          fib_next      = '0;
          overflow_next = 1'b0;
          state_next    = CALC;
        end
      end

      CALC: begin
        if (ov0_reg) begin
          // The current term already overflowed, so every later term will
          // too: stop early with a saturated result.
          fib_next      = '1;
          overflow_next = 1'b1;
          state_next    = DONE;
        end else if (cnt_reg == '0) begin
          fib_next      = t0_reg;
          overflow_next = 1'b0;
          state_next    = DONE;
        end else begin
          // Overflow flags shift along with the terms; a carry into t1 only
          // matters if that term later becomes t0 while cnt is still live.
          t0_next  = t1_reg;
          ov0_next = ov1_reg;
          t1_next  = sum[DATA_W-1:0];
          ov1_next = ov1_reg | sum[DATA_W];
          cnt_next = cnt_reg - 1'b1;
          idx_next = idx_reg + 1'b1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ready    = (state_reg == IDLE);
  assign done     = (state_reg == DONE);
  assign fib      = fib_reg;
  assign overflow = overflow_reg;

`ifdef FIB_STREAM_EN
  // Every CALC cycle with a non-overflowed t0 carries a term: all the
  // stepping cycles plus the cnt==0 terminating cycle.
  assign term_valid = (state_reg == CALC) && !ov0_reg;
  assign term       = t0_reg;
  assign term_idx   = idx_reg;
`endif

endmodule

// File: tb/tb_fibonacci_engine.sv
module tb_fibonacci_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [6:0]  n_drv;
  logic        sel;     // 0: 32-bit engine, 1: 8-bit engine

  logic        ready32, done32, ov32;
  logic [31:0] fib32;
  logic        ready8, done8, ov8;
  logic [7:0]  fib8;

`ifdef FIB_STREAM_EN
  logic        tv32, tv8;
  logic [31:0] term32;
  logic [6:0]  tidx32;
  logic [7:0]  term8;
  logic [4:0]  tidx8;
  longint unsigned tq[$];
  int          iq[$];
  int          eq[$];
`endif

  logic        start32, start8;
  logic        r_ready, r_done, r_ov;
  logic [31:0] r_fib;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign start32 = start && !sel;
  assign start8  = start && sel;
  assign r_ready = sel ? ready8 : ready32;
  assign r_done  = sel ? done8  : done32;
  assign r_ov    = sel ? ov8    : ov32;
  assign r_fib   = sel ? {24'b0, fib8} : fib32;

  fibonacci_engine #(.DATA_W(32), .IDX_W(7)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .n(n_drv),
    .ready(ready32), .done(done32), .fib(fib32), .overflow(ov32)
`ifdef FIB_STREAM_EN
    , .term_valid(tv32), .term(term32), .term_idx(tidx32)
`endif
  );

  fibonacci_engine #(.DATA_W(8), .IDX_W(5)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .n(n_drv[4:0]),
    .ready(ready8), .done(done8), .fib(fib8), .overflow(ov8)
`ifdef FIB_STREAM_EN
    , .term_valid(tv8), .term(term8), .term_idx(tidx8)
`endif
  );

  task automatic check(input string tag, input longint unsigned obs,
                       input longint unsigned exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: walk the sequence with plain arithmetic; the result is
  // available two cycles after the index of interest (or of first overflow).
  function automatic void fib_model(input int w, input int nn,
                                    output longint unsigned val,
                                    output bit ov, output int lat);
    longint unsigned a, b, tmp, lim;
    bit fin;
    a = 0; b = 1; lim = 64'd1 << w; fin = 0;
    val = 0; ov = 0; lat = 0;
    for (int j = 0; j <= nn; j++) begin
      if (!fin) begin
        if (a >= lim) begin
          val = lim - 1; ov = 1; lat = j + 2; fin = 1;
        end else if (j == nn) begin
          val = a; ov = 0; lat = nn + 2; fin = 1;
        end
        tmp = a + b; a = b; b = tmp;
      end
    end
  endfunction

  // One request: latency is counted in edges, the accepting edge being 1.
  task automatic do_req(input bit s, input int nn, input bit hold,
                        input int alt_n, output longint unsigned got);
    longint unsigned exp_val;
    bit exp_ov;
    int exp_lat, edges, waits;
    string tag;
    tag = $sformatf("w%0d_n%0d", s ? 8 : 32, nn);
    fib_model(s ? 8 : 32, nn, exp_val, exp_ov, exp_lat);
    sel = s;
    @(negedge clk);
    waits = 0;
    while (!r_ready && waits < 300) begin @(negedge clk); waits++; end
    if (waits >= 300) check({tag, "_ready_wait"}, 0, 1);
    start = 1'b1;
    n_drv = 7'(nn);
`ifdef FIB_STREAM_EN
    tq.delete(); iq.delete(); eq.delete();
`endif
    @(posedge clk); #1;
    edges = 1;
    check({tag, "_ready_low"}, r_ready, 0);
    while (!r_done && edges < 300) begin
`ifdef FIB_STREAM_EN
      if (!s && tv32) begin
        tq.push_back(term32); iq.push_back(int'(tidx32)); eq.push_back(edges);
      end
`endif
      if (edges == 2) begin
        if (hold) n_drv = 7'(alt_n);
        else start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    got = r_fib;
    check({tag, "_latency"}, edges, exp_lat);
    check({tag, "_fib"}, r_fib, exp_val);
    check({tag, "_ovf"}, r_ov, exp_ov);
    $display("req %s: fib=%0d ovf=%0d latency=%0d", tag, r_fib, r_ov, edges);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, r_done, 0);
    check({tag, "_ready_back"}, r_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    longint unsigned got, ev;
    bit eo;
    int el, dcount;

    rst_n = 1'b0; start = 1'b0; n_drv = '0; sel = 1'b0;
    #12;
    check("rst_ready32", ready32, 1);
    check("rst_done32", done32, 0);
    check("rst_fib32", fib32, 0);
    check("rst_ovf32", ov32, 0);
    check("rst_ready8", ready8, 1);
    check("rst_fib8", fib8, 0);
    @(negedge clk); rst_n = 1'b1;

    do_req(0, 10, 0, 0, got);  check("n10_is_55", got, 55);
    do_req(0, 0, 0, 0, got);   check("n0_is_0", got, 0);
    do_req(0, 1, 0, 0, got);   check("n1_is_1", got, 1);
    do_req(0, 47, 0, 0, got);  check("n47_value", got, 64'd2971215073);
    do_req(0, 48, 0, 0, got);  check("n48_sat", got, 64'hFFFF_FFFF);
    do_req(0, 100, 0, 0, got); check("n100_sat", got, 64'hFFFF_FFFF);
    do_req(0, 127, 0, 0, got);
    do_req(1, 13, 0, 0, got);  check("w8_n13_is_233", got, 233);
    do_req(1, 14, 0, 0, got);  check("w8_n14_sat", got, 255);
    do_req(1, 31, 0, 0, got);

    // start held and n changed while busy: one result for the original n
    do_req(0, 20, 1, 5, got);  check("held_start_6765", got, 6765);
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done32) dcount++;
    end
    check("held_start_no_extra_done", dcount, 0);

    // reset in the middle of a calculation
    sel = 1'b0;
    @(negedge clk); start = 1'b1; n_drv = 7'd20;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", ready32, 1);
    check("midrst_done", done32, 0);
    check("midrst_fib", fib32, 0);
    check("midrst_ovf", ov32, 0);
    @(negedge clk); rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done32) dcount++;
    end
    check("midrst_no_done", dcount, 0);
    do_req(0, 7, 0, 0, got);   check("after_rst_n7_is_13", got, 13);

`ifdef FIB_STREAM_EN
    do_req(0, 5, 0, 0, got);
    check("stream_count", tq.size(), 6);
    for (int i = 0; i < tq.size() && i < 6; i++) begin
      fib_model(32, i, ev, eo, el);
      check($sformatf("stream_term%0d", i), tq[i], ev);
      check($sformatf("stream_idx%0d", i), iq[i], i);
      check($sformatf("stream_cycle%0d", i), eq[i], i + 1);
    end
`endif

    for (int i = 0; i < 6; i++) begin
      do_req(0, int'($urandom_range(0, 127)), 0, 0, got);
      do_req(1, int'($urandom_range(0, 31)), 0, 0, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
